// File: rtl/expr_emitter.sv
// Serialises a latched list of BCD digits and '+'/'*' operators into an ASCII byte stream.
// Optional: define EXPR_TERM_EN to append an '=' terminator after the last digit.
module expr_emitter #(
  parameter  int MAX_TERMS = 8,
  localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [CNT_W-1:0]       term_cnt,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  input  logic                   out_ready,
  output logic [7:0]             out_char,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

`ifdef EXPR_TERM_EN
  typedef enum logic [2:0] {IDLE, DIGIT, OP, TERM, FIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, DIGIT, OP, FIN} state_t;
`endif

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       idx, idx_nxt;
  logic [CNT_W-1:0]       lat_n;
  logic [4*MAX_TERMS-1:0] lat_digits;
  logic [MAX_TERMS-2:0]   lat_ops;
  logic                   req_ok;
  logic                   load;
  logic                   err_nxt;
  logic [3:0]             cur_digit;
  logic                   cur_op;

  // Only digits below term_cnt take part in validation; the rest are don't-care.
  always_comb begin
    req_ok = (term_cnt != '0) && (term_cnt <= CNT_W'(MAX_TERMS));
    for (int unsigned i = 0; i < MAX_TERMS; i++) begin
      if ((CNT_W'(i) < term_cnt) && (digits[4*i +: 4] > 4'd9)) req_ok = 1'b0;
    end
  end

  always_comb begin
    cur_digit = '0;
    cur_op    = 1'b0;
    for (int unsigned i = 0; i < MAX_TERMS; i++) begin
      if (idx == CNT_W'(i)) cur_digit = lat_digits[4*i +: 4];
    end
    for (int unsigned i = 0; i < MAX_TERMS - 1; i++) begin
      if (idx == CNT_W'(i)) cur_op = lat_ops[i];
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    out_char  = '0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    err_nxt   = (state == IDLE) && start && !req_ok;
    case (state)
      IDLE: begin
        if (start && req_ok) begin
          load      = 1'b1;
          idx_nxt   = '0;
          state_nxt = DIGIT;
        end
      end
      DIGIT: begin
        out_char  = 8'h30 + {4'h0, cur_digit};
        out_valid = 1'b1;
        if (out_ready) begin
`ifdef EXPR_TERM_EN
          state_nxt = (idx == lat_n - CNT_W'(1)) ? TERM : OP;
`else
          state_nxt = (idx == lat_n - CNT_W'(1)) ? FIN : OP;
`endif
        end
      end
      OP: begin
        out_char  = cur_op ? 8'h2A : 8'h2B;
        out_valid = 1'b1;
        if (out_ready) begin
          idx_nxt   = idx + CNT_W'(1);
          state_nxt = DIGIT;
        end
      end
`ifdef EXPR_TERM_EN
      TERM: begin
        out_char  = 8'h3D;
        out_valid = 1'b1;
        if (out_ready) state_nxt = FIN;
      end
`endif
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      idx        <= '0;
      lat_n      <= '0;
      lat_digits <= '0;
      lat_ops    <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      err   <= err_nxt;
      if (load) begin
        lat_n      <= term_cnt;
        lat_digits <= digits;
        lat_ops    <= ops;
      end
    end
  end

endmodule

// File: tb/tb_expr_emitter.sv
// Scoreboard bench for expr_emitter: a string-level model queues expected events,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_expr_emitter;

  localparam int EV_DONE = 256;
  localparam int EV_ERR  = 257;
`ifdef EXPR_TERM_EN
  localparam int TERM_EXTRA = 1;
`else
  localparam int TERM_EXTRA = 0;
`endif

  logic        clk;
  logic        clr;
  logic        start;
  logic [3:0]  term_cnt;
  logic [31:0] digits;
  logic [6:0]  ops;
  logic        out_ready = 1'b1;
  logic [7:0]  out_char;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t_start = 0;
  int last_done = 0;
  int exp_q[$];
  bit ready_q[$];
  bit rand_ready = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_char = '0;

  expr_emitter #(.MAX_TERMS(8)) dut (
    .clk(clk), .clr(clr), .start(start), .term_cnt(term_cnt), .digits(digits),
    .ops(ops), .out_ready(out_ready), .out_char(out_char), .out_valid(out_valid),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) begin
    #2;
    if (ready_q.size() > 0) out_ready = ready_q.pop_front();
    else if (rand_ready)    out_ready = ($urandom_range(0, 3) != 0);
    else                    out_ready = 1'b1;
  end

  always @(negedge clk) begin
    int ev;
    int e;
    if (clr) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_hold", int'(out_char), int'(prev_char));
      end
      if (done || err) check("done_err_excl", int'(done & err), 0);
      ev = -1;
      if (out_valid && out_ready) ev = int'(out_char);
      else if (done)              ev = EV_DONE;
      else if (err)               ev = EV_ERR;
      if (ev >= 0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: got %0h, expected nothing (cycle %0d)", ev, cyc);
        end else begin
          e = exp_q.pop_front();
          check("stream", ev, e);
        end
        if (ev == EV_DONE) last_done = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_char  = out_char;
    end
  end

  // Reference: build the expected character string from the request's rules.
  task automatic issue(input int n, input logic [31:0] d, input logic [6:0] o);
    bit ok;
    ok = (n >= 1) && (n <= 8);
    for (int i = 0; i < n && i < 8; i++)
      if (d[4*i +: 4] > 4'd9) ok = 1'b0;
    if (!ok) begin
      exp_q.push_back(EV_ERR);
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(48 + int'(d[4*i +: 4]));
        if (i < n - 1) exp_q.push_back(o[i] ? 42 : 43);
      end
      if (TERM_EXTRA == 1) exp_q.push_back(61);
      exp_q.push_back(EV_DONE);
    end
    term_cnt = n[3:0];
    digits   = d;
    ops      = o;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    t_start = cyc;
  endtask

  task automatic raw_start(input logic [3:0] n, input logic [31:0] d, input logic [6:0] o);
    term_cnt = n;
    digits   = d;
    ops      = o;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (!busy && exp_q.size() == 0) return;
    end
    tests++;
    fails++;
    $display("FAIL idle_timeout: busy=%0b, %0d events still expected", busy, exp_q.size());
    exp_q.delete();
  endtask

  task automatic check_lat(input int n, input int stalls);
    check("latency", last_done - t_start, 2*n - 1 + stalls + TERM_EXTRA);
  endtask

  initial begin
    logic [31:0] d;
    int n;
    clr = 1'b1; start = 1'b0; term_cnt = '0; digits = '0; ops = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_char", int'(out_char), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    clr = 1'b0;
    @(posedge clk);
    #1;

    // "7+0*9" at full rate
    issue(3, 32'h0000_0907, 7'b0000010);
    wait_idle();
    check_lat(3, 0);

    // single digit
    issue(1, 32'h0000_0005, 7'b0);
    wait_idle();
    check_lat(1, 0);

    // rejections followed by an accepted request
    issue(0, 32'h0000_0001, 7'b0);
    issue(2, 32'h0000_00A4, 7'b0);
    issue(9, 32'h1234_5678, 7'b0);
    issue(2, 32'h0000_0021, 7'b1);
    wait_idle();
    check_lat(2, 0);

    // backpressure on the '*' plus ignored starts while busy
    rand_ready = 1'b0;
    ready_q.push_back(1'b1);
    ready_q.push_back(1'b1);
    ready_q.push_back(1'b0);
    ready_q.push_back(1'b0);
    ready_q.push_back(1'b0);
    issue(2, 32'h0000_0043, 7'b1);
    @(posedge clk);
    #1;
    raw_start(4'd0, 32'h0, 7'b0);
    raw_start(4'd1, 32'h0000_0009, 7'b0);
    wait_idle();
    check_lat(2, 3);

    // asynchronous clear after "1+", then full re-emission
    issue(3, 32'h0000_0321, 7'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    clr = 1'b1;
    #1;
    check("clr_out_valid", int'(out_valid), 0);
    check("clr_busy", int'(busy), 0);
    check("clr_out_char", int'(out_char), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    clr = 1'b0;
    issue(3, 32'h0000_0321, 7'b0);
    wait_idle();
    check_lat(3, 0);

    issue(2, 32'h0000_0028, 7'b0);
    wait_idle();
    check_lat(2, 0);

    // randomized requests with random backpressure
    rand_ready = 1'b1;
    for (int it = 0; it < 60; it++) begin
      n = ($urandom_range(0, 15) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      for (int i = 0; i < 8; i++)
        d[4*i +: 4] = (i < n) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) d[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
      issue(n, d, 7'($urandom));
      wait_idle();
    end

    rand_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
